// File: rtl/lbdr_dr_pkg.sv
// Shared definitions for the lbdr_dr routing unit: flit type encodings,
// output-port indices, FSM state type and deroute field encodings.
package lbdr_dr_pkg;

    // Flit type encodings carried on flit_id
    localparam logic [2:0] FLIT_HEADER = 3'b001;
    localparam logic [2:0] FLIT_BODY   = 3'b010;
    localparam logic [2:0] FLIT_TAIL   = 3'b100;

    // Bit positions inside port_req {L,S,W,E,N}
    localparam int P_N = 0;
    localparam int P_E = 1;
    localparam int P_W = 2;
    localparam int P_S = 3;
    localparam int P_L = 4;
    localparam int NUM_PORTS = 5;

    // Deroute field encodings; the code value doubles as the Cx bit index
    localparam logic [1:0] DR_N = 2'b00;
    localparam logic [1:0] DR_E = 2'b01;
    localparam logic [1:0] DR_W = 2'b10;
    localparam logic [1:0] DR_S = 2'b11;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Map a deroute code onto a one-hot port_req vector
    function automatic logic [NUM_PORTS-1:0] dr_onehot(input logic [1:0] code);
        logic [NUM_PORTS-1:0] oh;
        oh = '0;
        case (code)
            DR_N:    oh[P_N] = 1'b1;
            DR_E:    oh[P_E] = 1'b1;
            DR_W:    oh[P_W] = 1'b1;
            default: oh[P_S] = 1'b1;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/lbdr_dr_route.sv
// Combinational route computation: coordinate comparators, LBDR minimal
// output set and the deroute fallback when no minimal port is usable.
module lbdr_dr_route
    import lbdr_dr_pkg::*;
#(
    parameter int X_W        = 2,
    parameter int Y_W        = 2,
    parameter bit EN_DEROUTE = 1'b1
) (
    input  logic [Y_W+X_W-1:0]   dst_addr,
    input  logic [Y_W+X_W-1:0]   cur_addr,
    input  logic [7:0]           rxy,
    input  logic [3:0]           cx,
    input  logic [7:0]           dr,
    output logic [NUM_PORTS-1:0] port_req,
    output logic                 derouted,
    output logic                 unroutable
);

    localparam int A_W = Y_W + X_W;

    logic [X_W-1:0] x_dst, x_cur;
    logic [Y_W-1:0] y_dst, y_cur;
    logic n1, s1, e1, w1;
    logic rne, rnw, ren, res, rwn, rws, rse, rsw;
    logic cn, ce, cw, cs;

    assign x_dst = dst_addr[X_W-1:0];
    assign y_dst = dst_addr[A_W-1:X_W];
    assign x_cur = cur_addr[X_W-1:0];
    assign y_cur = cur_addr[A_W-1:X_W];

    assign n1 = (y_dst < y_cur);
    assign s1 = (y_dst > y_cur);
    assign e1 = (x_dst > x_cur);
    assign w1 = (x_dst < x_cur);

    assign {rsw, rse, rws, rwn, res, ren, rnw, rne} = rxy;
    assign {cs, cw, ce, cn} = cx;

    // Minimal set first, then fall back to the deroute port of the primary direction
    always_comb begin
        logic [NUM_PORTS-1:0] min_set;
        logic [1:0]           sel;

        min_set         = '0;
        min_set[P_N]    = ((n1 & ~e1 & ~w1) | (n1 & e1 & rne) | (n1 & w1 & rnw)) & cn;
        min_set[P_E]    = ((e1 & ~n1 & ~s1) | (e1 & n1 & ren) | (e1 & s1 & res)) & ce;
        min_set[P_W]    = ((w1 & ~n1 & ~s1) | (w1 & n1 & rwn) | (w1 & s1 & rws)) & cw;
        min_set[P_S]    = ((s1 & ~e1 & ~w1) | (s1 & e1 & rse) | (s1 & w1 & rsw)) & cs;
        min_set[P_L]    = ~n1 & ~e1 & ~w1 & ~s1;

        if (n1)      sel = dr[1:0];
        else if (s1) sel = dr[7:6];
        else if (e1) sel = dr[3:2];
        else         sel = dr[5:4];

        port_req   = min_set;
        derouted   = 1'b0;
        unroutable = 1'b0;

        if (EN_DEROUTE && (min_set == '0)) begin
            if (cx[sel]) begin
                port_req = dr_onehot(sel);
                derouted = 1'b1;
            end else begin
                unroutable = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lbdr_dr.sv
// Per-input-port LBDR routing unit with deroute fallback. Latches the route
// on a HEADER pop and holds it, across FIFO bubbles, until the TAIL pop.
module lbdr_dr
    import lbdr_dr_pkg::*;
#(
    parameter int X_W        = 2,
    parameter int Y_W        = 2,
    parameter bit EN_DEROUTE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 empty,
    input  logic                 flit_pop,
    input  logic [2:0]           flit_id,
    input  logic [Y_W+X_W-1:0]   dst_addr,
    input  logic [Y_W+X_W-1:0]   cur_addr_rst,
    input  logic [7:0]           Rxy_rst,
    input  logic [3:0]           Cx_rst,
    input  logic [7:0]           DR_rst,
    output logic [NUM_PORTS-1:0] port_req,
    output logic                 route_valid,
    output logic                 derouted,
    output logic                 proto_err
);

    logic [Y_W+X_W-1:0]   cur_addr_q;
    logic [7:0]           rxy_q;
    logic [3:0]           cx_q;
    logic [7:0]           dr_q;
    state_t               state_q;

    logic [NUM_PORTS-1:0] r_req;
    logic                 r_der;
    logic                 r_unr;
    logic                 pop;
    logic                 is_head, is_body, is_tail;

    assign pop     = flit_pop & ~empty;
    assign is_head = (flit_id == FLIT_HEADER);
    assign is_body = (flit_id == FLIT_BODY);
    assign is_tail = (flit_id == FLIT_TAIL);

    lbdr_dr_route #(
        .X_W        (X_W),
        .Y_W        (Y_W),
        .EN_DEROUTE (EN_DEROUTE)
    ) u_route (
        .dst_addr   (dst_addr),
        .cur_addr   (cur_addr_q),
        .rxy        (rxy_q),
        .cx         (cx_q),
        .dr         (dr_q),
        .port_req   (r_req),
        .derouted   (r_der),
        .unroutable (r_unr)
    );

    // Configuration is captured while reset is held and frozen afterwards
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr_q <= cur_addr_rst;
            rxy_q      <= Rxy_rst;
            cx_q       <= Cx_rst;
            dr_q       <= DR_rst;
        end
    end

    // Packet FSM with registered outputs; only popped flits advance it
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            port_req    <= '0;
            route_valid <= 1'b0;
            derouted    <= 1'b0;
            proto_err   <= 1'b0;
        end else if (pop) begin
            case (state_q)
                ST_IDLE: begin
                    if (is_head) begin
                        port_req    <= r_req;
                        route_valid <= 1'b1;
                        derouted    <= r_der;
                        if (r_unr) proto_err <= 1'b1;
                        state_q     <= ST_ACTIVE;
                    end else begin
                        // BODY/TAIL with no open packet: drop it and flag
                        proto_err <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (is_tail) begin
                        port_req    <= '0;
                        route_valid <= 1'b0;
                        derouted    <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else if (is_head) begin
                        // Missing tail: flag it and route the new packet
                        port_req    <= r_req;
                        route_valid <= 1'b1;
                        derouted    <= r_der;
                        proto_err   <= 1'b1;
                    end else if (!is_body) begin
                        proto_err <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/lbdr_dr.md
# lbdr_dr

Parametrised logic-based distributed routing unit with deroute support and packet-level output hold, one instance per router input port. It computes the minimal-route candidate output set from a HEADER flit using per-port routing (Rxy) and connectivity (Cx) bits. When no minimal port is connected, it falls back to a configured deroute port. It holds the selected ports for the whole packet, through FIFO-empty bubbles, until the TAIL flit is popped. It sits between the input FIFO and the switch allocator.

## Interface
- X_W, 2, bits of X coordinate
- Y_W, 2, bits of Y coordinate
- EN_DEROUTE, 1, 1 enables deroute fallback; 0 gives minimal-only behaviour
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- empty  in  1  input FIFO empty
- flit_pop  in  1  head flit consumed this cycle; ignored when empty=1
- flit_id  in  3  HEADER/BODY/TAIL encoding from shared parameters
- dst_addr  in  Y_W+X_W  destination, {y,x}
- cur_addr_rst  in  Y_W+X_W  local address, sampled while rst=1
- Rxy_rst  in  8  routing bits {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}, sampled while rst=1
- Cx_rst  in  4  connectivity bits {Cs,Cw,Ce,Cn}, sampled while rst=1
- DR_rst  in  8  deroute fields, 2 bits per primary direction {S,W,E,N}; 00=N 01=E 10=W 11=S; sampled while rst=1
- port_req  out  5  {L,S,W,E,N} candidate set, may be multi-hot
- route_valid  out  1  port_req is valid for the current packet
- derouted  out  1  current packet took the deroute port
- proto_err  out  1  sticky protocol error

## Operation
- Config registers (Rxy, Cx, DR, cur_addr) load every cycle rst=1 and are static otherwise.
- Comparators, unsigned: N1=y_dst<y_cur, S1=y_dst>y_cur, E1=x_dst>x_cur, W1=x_dst<x_cur.
- Minimal set, as in the base LBDR:
  - N = (N1&~E1&~W1 | N1&E1&Rne | N1&W1&Rnw) & Cn.
  - E, W and S follow the same pattern, each using its own R bits and C bit.
  - L = ~N1&~E1&~W1&~S1.
- Deroute: applies when EN_DEROUTE=1, the minimal set is zero, and L=0.
  - Primary direction priority: N1, then S1, then E1, then W1.
  - The primary direction's DR field selects the port. If that port's C bit is 1, port_req is one-hot on it and derouted=1.
  - If that port's C bit is 0, port_req=0, route_valid=1 and proto_err is set (unroutable).
- FSM states: IDLE, ACTIVE.
  - IDLE + (~empty & flit_pop & HEADER): latch the result, then ACTIVE.
  - ACTIVE + (~empty & flit_pop & TAIL): clear the outputs, then IDLE.
  - ACTIVE + BODY pop: stay in ACTIVE.
  - ACTIVE + HEADER pop: set proto_err, re-route with the new header, stay in ACTIVE.
  - IDLE + BODY/TAIL pop: set proto_err, ignore the flit, stay in IDLE.
- empty=1 never clears the outputs; the route is held across bubbles.
- flit_pop while empty=1 is ignored.
- proto_err clears only on rst.

## Timing
- All outputs are registered.
- Reset values: port_req=0, route_valid=0, derouted=0, proto_err=0, state IDLE.
- Header popped at cycle t: port_req, route_valid and derouted are valid at t+1.
- Tail popped at cycle t: outputs are 0 at t+1.
- Header and tail must be in separate flits. A new header may be popped at the cycle immediately after the tail.
- rst mid-packet: outputs are 0 and state is IDLE at the next edge. In-flight flits are then treated per IDLE rules, so BODY/TAIL pops set proto_err.
- Config changes only take effect through rst.

## Structure
- Shared package holds:
  - flit_id encodings (HEADER, BODY, TAIL);
  - port index constants (N=0, E=1, W=2, S=3, L=4);
  - the state enum;
  - DR field encodings.
- One sub-module, lbdr_dr_route: purely combinational comparator, minimal-set and deroute logic, parametrised by X_W and Y_W. The top module holds the config registers and the FSM.

## Test plan
All cases use X_W=Y_W=2, cur=5, Rxy=8'h3C, Cx=4'hF, DR=8'hE4 unless stated.
- Minimal N: header dst=1 -> port_req=5'b00001 at t+1, route_valid=1, derouted=0.
- Local: header dst=5 -> port_req=5'b10000.
- Routing-bit selection: header dst=4'hF -> port_req=5'b00010 (E only, since Rse=0).
- Deroute: Cx=4'b1110, DR[1:0]=01, header dst=1 -> port_req=5'b00010, derouted=1.
- Hold through bubbles: header dst=1 popped, empty=1 for 3 cycles, BODY pop, TAIL pop -> port_req=5'b00001 held throughout, 0 the cycle after the tail.
- Protocol/reset: BODY pop in IDLE -> proto_err=1, outputs 0. Reset asserted mid-packet -> all outputs 0 next cycle, proto_err=0.
